// File: rtl/pulse_handshake_tx.sv
// Source-side req/ack pulse crossing: din events become a four-phase
// handshake; one event is queued while busy, further ones are counted.
//
// Ports:
//   clka     - source clock (the only clock here)
//   rst_n    - asynchronous active-low reset
//   din      - event strobe, one event per cycle sampled high
//   ack      - handshake ack from the clkb domain (asynchronous)
//   req      - registered handshake request level
//   busy     - FSM not idle
//   pend     - one event queued
//   done     - one-cycle pulse when the receiver accepted an event
//   drop_cnt - saturating count of dropped events
module pulse_handshake_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             din,
  input  logic             ack,
  output logic             req,
  output logic             busy,
  output logic             pend,
  output logic             done,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] ack_q;
  logic                   ack_s;

  logic avail;
  logic launch;
  logic din_q;
  logic pend_left;
  logic req_nxt;
  logic done_nxt;
  logic pend_nxt;
  logic drop_inc;

  assign ack_s = ack_q[SYNC_STAGES-1];

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= '0;
      state    <= S_IDLE;
      req      <= 1'b0;
      done     <= 1'b0;
      pend     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ack_q <= {ack_q[SYNC_STAGES-2:0], ack};
      state <= state_nxt;
      req   <= req_nxt;
      done  <= done_nxt;
      pend  <= pend_nxt;
      if (drop_inc && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  // A launch is only possible outside REQ, and only once the
  // previous ack has been seen low again.
  assign avail  = din | pend;
  assign launch = avail & ~ack_s & (state != S_REQ);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (launch) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (ack_s) state_nxt = S_REL;
      end
      S_REL: begin
        if (launch)      state_nxt = S_REQ;
        else if (!ack_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The queued event always launches before a same-cycle din, so din
  // is launched directly only when nothing is pending.
  always_comb begin
    req_nxt   = (state_nxt == S_REQ);
    done_nxt  = (state == S_REQ) & ack_s;
    din_q     = din & ~(launch & ~pend);
    pend_left = pend & ~launch;
    pend_nxt  = pend_left | din_q;
    drop_inc  = din_q & pend_left;
  end

  assign busy = (state != S_IDLE);

endmodule
